// File: rtl/mem_pkg.sv
// Shared encodings for the load/store request stage: access sizes, FSM states
// and the alignment rule that decides whether a request ever reaches the bus.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CMD  = 2'b01,
    WAIT = 2'b10,
    RSP  = 2'b11
  } state_e;

  // Reserved size is reported through the same error path as misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_wdata_align.sv
// Lane alignment for stores: byte strobes from size/offset and store data
// replicated across lanes so the selected lanes always carry the right bytes.
module mem_wdata_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o
);

  // Strobe and replicated data per access size.
  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        wstrb_o = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        wstrb_o = 4'b0011 << off_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      SZ_WORD: begin
        wstrb_o = 4'b1111;
        wdata_o = wdata_i;
      end
      default: begin
        wstrb_o = 4'b0000;
        wdata_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store request stage: latches one request, issues it on
// the word bus, and returns the raw completion word with the latched size/offset.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic [31:0]           req_wdata,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_wstrb,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_rvalid,
  input  logic [31:0]           bus_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [1:0]            rsp_size,
  output logic [1:0]            rsp_offset,
  output logic                  rsp_err
);

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              size_q, size_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [3:0]              strb_s;
  logic [31:0]             algn_wdata_s;

  mem_wdata_align u_align (
    .size_i  (size_q),
    .off_i   (addr_q[1:0]),
    .wdata_i (wdata_q),
    .wstrb_o (strb_s),
    .wdata_o (algn_wdata_s)
  );

  // Next-state and request/response latches.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          size_d  = req_size;
          wdata_d = req_wdata;
          rdata_d = 32'h0000_0000;
          err_d   = is_misaligned(req_size, req_addr[1:0]);
          state_d = is_misaligned(req_size, req_addr[1:0]) ? RSP : CMD;
        end else begin
          state_d = IDLE;
        end
      end
      CMD: begin
        // A completion coincident with the bus handshake skips WAIT.
        if (bus_ready && bus_rvalid) begin
          rdata_d = we_q ? 32'h0000_0000 : bus_rdata;
          state_d = RSP;
        end else if (bus_ready) begin
          state_d = WAIT;
        end else begin
          state_d = CMD;
        end
      end
      WAIT: begin
        if (bus_rvalid) begin
          rdata_d = we_q ? 32'h0000_0000 : bus_rdata;
          state_d = RSP;
        end else begin
          state_d = WAIT;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RSP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      wdata_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign bus_valid  = (state_q == CMD);
  assign bus_we     = we_q;
  assign bus_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus_wstrb  = we_q ? strb_s : 4'b0000;
  assign bus_wdata  = algn_wdata_s;
  assign rsp_valid  = (state_q == RSP);
  assign rsp_data   = rdata_q;
  assign rsp_size   = size_q;
  assign rsp_offset = addr_q[1:0];
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// transactions checked against a size/offset arithmetic reference model.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_size, rsp_offset;

  int vectors = 0;
  int miscompares = 0;

  logic        obs_bus_seen, obs_rsp_seen, obs_unstable, obs_rr_bad, obs_after_ok, obs_we;
  logic [31:0] obs_addr, obs_wd, obs_rdata;
  logic [3:0]  obs_strb;
  logic [1:0]  obs_size, obs_off;
  logic        obs_err;
  int          obs_lat;

  mem_access_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_size(rsp_size), .rsp_offset(rsp_offset), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_bytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd3) return 1'b1;
    return (addr % m_bytes(size)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [1:0] size, input logic [31:0] addr);
    int nb;
    int mask;
    nb = m_bytes(size);
    mask = ((1 << nb) - 1) << (addr % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    int nb;
    nb = m_bytes(size);
    r = 32'h0;
    for (int k = 0; k < 4; k++) r = r | (((wd >> (8 * (k % nb))) & 32'hFF) << (8 * k));
    return r;
  endfunction

  // ---------------- transaction driver / monitor ----------------
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int bus_stall, input int rsp_stall, input logic rv_same);
    int   stall_cnt;
    int   lat;
    logic rv_pend;
    logic done;
    obs_bus_seen = 1'b0; obs_rsp_seen = 1'b0; obs_unstable = 1'b0;
    obs_rr_bad = 1'b0; obs_after_ok = 1'b0; obs_lat = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_size = 2'($urandom); req_wdata = $urandom;
    stall_cnt = 0; rv_pend = 1'b0; lat = 1; done = 1'b0;
    while (!done && lat < 60) begin
      bus_rvalid = 1'b0;
      bus_rdata  = $urandom;
      if (rv_pend) begin
        bus_rvalid = 1'b1; bus_rdata = rdata; rv_pend = 1'b0;
      end
      if (req_ready) obs_rr_bad = 1'b1;
      if (rsp_valid) begin
        obs_rsp_seen = 1'b1; obs_lat = lat; done = 1'b1; bus_ready = 1'b0;
      end else if (bus_valid) begin
        if (!obs_bus_seen) begin
          obs_bus_seen = 1'b1; obs_addr = bus_addr; obs_we = bus_we;
          obs_strb = bus_wstrb; obs_wd = bus_wdata;
        end else if ({obs_addr, obs_we, obs_strb, obs_wd} !== {bus_addr, bus_we, bus_wstrb, bus_wdata}) begin
          obs_unstable = 1'b1;
        end
        if (stall_cnt >= bus_stall) begin
          bus_ready = 1'b1;
          if (rv_same) begin bus_rvalid = 1'b1; bus_rdata = rdata; end
          else rv_pend = 1'b1;
        end else begin
          bus_ready = 1'b0; stall_cnt++;
        end
      end else begin
        bus_ready = 1'b0;
      end
      if (!done) begin @(posedge clk); #1; lat++; end
    end
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    if (!done) return;
    obs_rdata = rsp_data; obs_size = rsp_size; obs_off = rsp_offset; obs_err = rsp_err;
    for (int i = 0; i < rsp_stall; i++) begin
      bus_rvalid = 1'b1; bus_rdata = $urandom;
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
      if (!rsp_valid || req_ready || {obs_rdata, obs_size, obs_off, obs_err} !== {rsp_data, rsp_size, rsp_offset, rsp_err})
        obs_unstable = 1'b1;
    end
    rsp_ready = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    obs_after_ok = !rsp_valid && req_ready && !bus_valid;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({req_ready, bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata, rsp_valid, rsp_data, rsp_size, rsp_offset, rsp_err}
        !== {1'b1, 108'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got req_ready=%b bus_valid=%b addr=%h wstrb=%b rsp_valid=%b data=%h",
               req_ready, bus_valid, bus_addr, bus_wstrb, rsp_valid, rsp_data);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({rsp_valid, bus_valid, req_ready, rsp_data} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL idle_rvalid_ignored: got rsp_valid=%b bus_valid=%b req_ready=%b data=%h, expected 0 0 1 0",
               rsp_valid, bus_valid, req_ready, rsp_data);
    end
  endtask

  task automatic test_load_word();
    run_txn(1'b0, 32'h100, 2'b10, 32'hCAFE_F00D, 32'hDEAD_BEEF, 0, 0, 1'b0);
    vectors++;
    if ({obs_bus_seen, obs_addr, obs_we, obs_strb} !== {1'b1, 32'h100, 1'b0, 4'b0000}) begin
      miscompares++;
      $display("FAIL load_word_bus: got seen=%b addr=%h we=%b strb=%b, expected 1 00000100 0 0000",
               obs_bus_seen, obs_addr, obs_we, obs_strb);
    end
    vectors++;
    if ({obs_rdata, obs_size, obs_off, obs_err} !== {32'hDEAD_BEEF, 2'b10, 2'b00, 1'b0}) begin
      miscompares++;
      $display("FAIL load_word_rsp: got data=%h size=%b off=%b err=%b, expected deadbeef 10 00 0",
               obs_rdata, obs_size, obs_off, obs_err);
    end
    vectors++;
    if (obs_lat !== 3) begin
      miscompares++;
      $display("FAIL load_word_latency: got %0d expected 3", obs_lat);
    end
  endtask

  task automatic test_store_byte();
    run_txn(1'b1, 32'h203, 2'b00, 32'h0000_00A5, 32'h5555_5555, 0, 0, 1'b0);
    vectors++;
    if ({obs_addr, obs_we, obs_strb, obs_wd} !== {32'h200, 1'b1, 4'b1000, 32'hA5A5_A5A5}) begin
      miscompares++;
      $display("FAIL store_byte_bus: got addr=%h we=%b strb=%b wdata=%h, expected 00000200 1 1000 a5a5a5a5",
               obs_addr, obs_we, obs_strb, obs_wd);
    end
    vectors++;
    if ({obs_rsp_seen, obs_rdata, obs_err, obs_off, obs_after_ok} !== {1'b1, 32'h0, 1'b0, 2'b11, 1'b1}) begin
      miscompares++;
      $display("FAIL store_byte_rsp: got seen=%b data=%h err=%b off=%b after=%b, expected 1 0 0 11 1",
               obs_rsp_seen, obs_rdata, obs_err, obs_off, obs_after_ok);
    end
  endtask

  task automatic test_store_half();
    run_txn(1'b1, 32'h102, 2'b01, 32'hFFFF_1234, 32'h0, 0, 0, 1'b0);
    vectors++;
    if ({obs_addr, obs_strb, obs_wd} !== {32'h100, 4'b1100, 32'h1234_1234}) begin
      miscompares++;
      $display("FAIL store_half_bus: got addr=%h strb=%b wdata=%h, expected 00000100 1100 12341234",
               obs_addr, obs_strb, obs_wd);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    addrs[0] = 32'h101; sizes[0] = 2'b01;
    addrs[1] = 32'h102; sizes[1] = 2'b10;
    addrs[2] = 32'h104; sizes[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b0, addrs[i], sizes[i], 32'h0, 32'hFFFF_FFFF, 0, 1, 1'b0);
      vectors++;
      if ({obs_bus_seen, obs_err, obs_rdata, obs_off, obs_size, obs_lat[3:0]}
          !== {1'b0, 1'b1, 32'h0, addrs[i][1:0], sizes[i], 4'd1}) begin
        miscompares++;
        $display("FAIL misaligned_%0d: got bus=%b err=%b data=%h off=%b size=%b lat=%0d, expected 0 1 0 %b %b 1",
                 i, obs_bus_seen, obs_err, obs_rdata, obs_off, obs_size, obs_lat, addrs[i][1:0], sizes[i]);
      end
    end
  endtask

  task automatic test_stall();
    run_txn(1'b1, 32'h3C0, 2'b10, 32'h8765_4321, 32'h0, 5, 3, 1'b0);
    vectors++;
    if ({obs_unstable, obs_rr_bad, obs_after_ok, obs_strb, obs_wd} !== {1'b0, 1'b0, 1'b1, 4'b1111, 32'h8765_4321}) begin
      miscompares++;
      $display("FAIL stall_hold: got unstable=%b rr_bad=%b after=%b strb=%b wdata=%h, expected 0 0 1 1111 87654321",
               obs_unstable, obs_rr_bad, obs_after_ok, obs_strb, obs_wd);
    end
    vectors++;
    if (obs_lat !== 8) begin
      miscompares++;
      $display("FAIL stall_latency: got %0d expected 8", obs_lat);
    end
  endtask

  task automatic test_same_cycle_rvalid();
    run_txn(1'b0, 32'h44, 2'b00, 32'h0, 32'h0BAD_F00D, 1, 0, 1'b1);
    vectors++;
    if ({obs_rdata, obs_lat[3:0], obs_strb} !== {32'h0BAD_F00D, 4'd3, 4'b0000}) begin
      miscompares++;
      $display("FAIL same_cycle_rvalid: got data=%h lat=%0d strb=%b, expected 0badf00d 3 0000",
               obs_rdata, obs_lat, obs_strb);
    end
  endtask

  task automatic test_reset_midflight();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h300; req_size = 2'b10;
    @(posedge clk); #1;
    req_valid = 1'b0; bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    rst = 1'b0;
    #2;
    vectors++;
    if ({req_ready, bus_valid, rsp_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_in_wait: got req_ready=%b bus_valid=%b rsp_valid=%b, expected 1 0 0",
               req_ready, bus_valid, rsp_valid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    bus_rvalid = 1'b1; bus_rdata = 32'hAAAA_5555;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({rsp_valid, req_ready, bus_valid} !== 3'b010) begin
        miscompares++;
        $display("FAIL reset_late_rvalid_%0d: got rsp_valid=%b req_ready=%b bus_valid=%b, expected 0 1 0",
                 i, rsp_valid, req_ready, bus_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic        we;
    logic [31:0] addr, wd, rd;
    logic [1:0]  size;
    int          bst, rst_cnt;
    logic        e;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom); addr = $urandom; size = 2'($urandom); wd = $urandom; rd = $urandom;
      bst = $urandom_range(0, 3); rst_cnt = $urandom_range(0, 2);
      e = m_err(size, addr);
      run_txn(we, addr, size, wd, rd, bst, rst_cnt, 1'b0);
      vectors++;
      if ({obs_rsp_seen, obs_unstable, obs_rr_bad, obs_after_ok} !== 4'b1001) begin
        miscompares++;
        $display("FAIL rand_%0d_flow: got seen=%b unstable=%b rr_bad=%b after=%b, expected 1 0 0 1",
                 n, obs_rsp_seen, obs_unstable, obs_rr_bad, obs_after_ok);
      end
      vectors++;
      if ({obs_err, obs_size, obs_off, obs_rdata} !== {e, size, addr[1:0], (we || e) ? 32'h0 : rd}) begin
        miscompares++;
        $display("FAIL rand_%0d_rsp: got err=%b size=%b off=%b data=%h, expected %b %b %b %h",
                 n, obs_err, obs_size, obs_off, obs_rdata, e, size, addr[1:0], (we || e) ? 32'h0 : rd);
      end
      vectors++;
      if (obs_lat !== (e ? 1 : 3 + bst)) begin
        miscompares++;
        $display("FAIL rand_%0d_latency: got %0d expected %0d", n, obs_lat, e ? 1 : 3 + bst);
      end
      vectors++;
      if (e) begin
        if (obs_bus_seen !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_%0d_nobus: got bus_valid seen=%b expected 0", n, obs_bus_seen);
        end
      end else if ({obs_bus_seen, obs_we, obs_addr, obs_strb} !== {1'b1, we, addr & 32'hFFFF_FFFC, we ? m_strb(size, addr) : 4'b0000}
                   || (we && obs_wd !== m_wdata(size, wd))) begin
        miscompares++;
        $display("FAIL rand_%0d_bus: got seen=%b we=%b addr=%h strb=%b wdata=%h, expected 1 %b %h %b %h",
                 n, obs_bus_seen, obs_we, obs_addr, obs_strb, obs_wd,
                 we, addr & 32'hFFFF_FFFC, we ? m_strb(size, addr) : 4'b0000, m_wdata(size, wd));
      end
    end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 2'b00; req_wdata = 32'h0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0; rsp_ready = 1'b0;
    test_reset();
    test_load_word();
    test_store_byte();
    test_store_half();
    test_misaligned();
    test_stall();
    test_same_cycle_rvalid();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
